// File: rtl/nbit_iterative_shifter.sv
// Multi-cycle N-bit shifter: one bit position per clock, SLL/SRL/SRA/ROL.
// Start/busy/done handshake; Y holds its value until the next completion.
module nbit_iterative_shifter #(
    parameter int unsigned N   = 32,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [SHW-1:0] shamt,
    input  logic [N-1:0]   X,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   Y
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   work_q, work_d;
    logic [N-1:0]   y_q, y_d;
    logic [1:0]     op_q, op_d;
    logic [SHW-1:0] count_q, count_d;
    logic [N-1:0]   shifted;

    always_comb begin
        shifted = work_q;
        unique case (op_q)
            2'b00:   shifted = {work_q[N-2:0], 1'b0};
            2'b01:   shifted = {1'b0, work_q[N-1:1]};
            2'b10:   shifted = {work_q[N-1], work_q[N-1:1]};
            2'b11:   shifted = {work_q[N-2:0], work_q[N-1]};
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        y_d     = y_q;
        op_d    = op_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = X;
                    op_d    = op;
                    count_d = shamt;
                    if (shamt != '0) begin
                        state_d = StShift;
                    end else begin
                        // Zero shift completes immediately with the operand unchanged.
                        y_d     = X;
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                work_d  = shifted;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    y_d     = shifted;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            y_q     <= '0;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            y_q     <= y_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign Y    = y_q;

endmodule
